fftpower_avg: RTL and testbench

// - Downstream of the 128-point FFT top level; consumes its bit-reversed-corrected output stream.
// - Computes per-bin power |X|^2 = re^2 + im^2 and averages it over 2^LGAVG consecutive frames.
// - Emits one averaged spectrum per 2^LGAVG input frames, tagged with bin index and last-bin flag.

---
 rtl/fftpower_avg_pkg.sv | 13 +
 rtl/fftpower_avg_if.sv | 27 ++
 rtl/fftpower_avg_cmag_sq.sv | 33 +++
 rtl/fftpower_avg.sv | 163 ++++++++++++++++
 tb/tb_fftpower_avg.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fftpower_avg_pkg.sv
// Shared defaults and state encoding for the FFT power averager.
package fftpower_avg_pkg;

   localparam int DEF_IWIDTH  = 20;
   localparam int DEF_LGWIDTH = 7;
   localparam int DEF_LGAVG   = 4;

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      RUN       = 1'b1
   } state_t;

endpackage

// File: rtl/fftpower_avg_if.sv
// Sample stream in, averaged spectrum out.
interface fftpower_avg_if #(
   parameter int IWIDTH  = 20,
   parameter int LGWIDTH = 7,
   parameter int PWIDTH  = 2 * IWIDTH
);

   logic                  i_ce;
   logic                  i_sync;
   logic [2*IWIDTH-1:0]   i_sample;
   logic                  o_valid;
   logic [LGWIDTH-1:0]    o_bin;
   logic [PWIDTH-1:0]     o_power;
   logic                  o_last;
   logic                  o_resync;

   modport master (
      output i_ce, i_sync, i_sample,
      input  o_valid, o_bin, o_power, o_last, o_resync
   );

   modport slave (
      input  i_ce, i_sync, i_sample,
      output o_valid, o_bin, o_power, o_last, o_resync
   );

endinterface

// File: rtl/fftpower_avg_cmag_sq.sv
// Two-stage complex magnitude squared: re^2 and im^2, then their sum.
module fftpower_avg_cmag_sq #(
   parameter int IW = 20
) (
   input  logic            clk,
   input  logic            ce,
   input  logic [2*IW-1:0] sample,
   output logic [2*IW-1:0] power
);

   logic signed [IW-1:0] re;
   logic signed [IW-1:0] im;
   logic [2*IW-2:0]      sq_re_d;
   logic [2*IW-2:0]      sq_im_d;
   logic [2*IW-2:0]      sq_re;
   logic [2*IW-2:0]      sq_im;

   assign re = sample[2*IW-1:IW];
   assign im = sample[IW-1:0];

   // A square never exceeds 2^(2*IW-2), so 2*IW-1 bits hold it exactly.
   assign sq_re_d = (2*IW-1)'(re * re);
   assign sq_im_d = (2*IW-1)'(im * im);

   always_ff @(posedge clk) begin
      if (ce) begin
         sq_re <= sq_re_d;
         sq_im <= sq_im_d;
         power <= {1'b0, sq_re} + {1'b0, sq_im};
      end
   end

endmodule

// File: rtl/fftpower_avg.sv
// Per-bin FFT power averaged over 2^LGAVG frames.
module fftpower_avg
   import fftpower_avg_pkg::*;
#(
   parameter int IWIDTH  = DEF_IWIDTH,
   parameter int LGWIDTH = DEF_LGWIDTH,
   parameter int LGAVG   = DEF_LGAVG,
   parameter int PWIDTH  = 2 * IWIDTH
) (
   input  logic          i_clk,
   input  logic          i_reset,
   fftpower_avg_if.slave bus
);

   localparam int N  = 1 << LGWIDTH;
   localparam int AW = PWIDTH + LGAVG;
   localparam int FW = (LGAVG > 0) ? LGAVG : 1;
   localparam logic [FW-1:0]      FLAST = FW'((1 << LGAVG) - 1);
   localparam logic [LGWIDTH-1:0] BLAST = LGWIDTH'(N - 1);

   typedef struct packed {
      logic               vld;
      logic [LGWIDTH-1:0] bin;
      logic               first;
      logic               fin;
   } tag_t;

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   resync;

   logic [LGWIDTH-1:0]  bin_nxt;
   logic [LGWIDTH-1:0]  cur_bin;
   logic [FW-1:0]       frm;
   logic [FW-1:0]       cur_frm;
   tag_t                tag_in;
   tag_t                t1;
   tag_t                t2;
   tag_t                t3;
   logic [2*IWIDTH-1:0] smp1;
   logic [2*IWIDTH-1:0] pwr3;

   logic [AW-1:0]       ram [N];
   logic [AW-1:0]       ram_q;
   logic [AW-1:0]       acc;

   logic                vld_q;
   logic                last_q;
   logic                resync_q;
   logic [LGWIDTH-1:0]  bin_q;
   logic [PWIDTH-1:0]   pow_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= WAIT_SYNC;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT_SYNC: if (bus.i_ce && bus.i_sync) state_nxt = RUN;
         RUN:       state_nxt = RUN;
         default:   state_nxt = WAIT_SYNC;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      resync = 1'b0;
      unique case (state)
         WAIT_SYNC: accept = bus.i_ce && bus.i_sync;
         RUN: begin
            accept = bus.i_ce;
            resync = bus.i_ce && bus.i_sync && (bin_nxt != '0);
         end
         default: ;
      endcase
   end

   // A sync off bin 0 also drops the partial average by restarting at frame 0.
   assign cur_bin = bus.i_sync ? '0 : bin_nxt;
   assign cur_frm = (bus.i_sync && bin_nxt != '0) ? '0 : frm;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bin_nxt <= '0;
         frm     <= '0;
      end else if (accept) begin
         bin_nxt <= cur_bin + LGWIDTH'(1);
         if (cur_bin == BLAST && LGAVG > 0) frm <= cur_frm + FW'(1);
         else                               frm <= cur_frm;
      end
   end

   assign tag_in = '{
      vld:   accept,
      bin:   cur_bin,
      first: (cur_frm == '0),
      fin:   (cur_frm == FLAST)
   };

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         t1 <= '0;
         t2 <= '0;
         t3 <= '0;
      end else if (bus.i_ce) begin
         t1 <= tag_in;
         t2 <= t1;
         t3 <= t2;
      end
   end

   always_ff @(posedge i_clk) begin
      if (bus.i_ce) smp1 <= bus.i_sample;
   end

   fftpower_avg_cmag_sq #(.IW(IWIDTH)) u_cmag (
      .clk    (i_clk),
      .ce     (bus.i_ce),
      .sample (smp1),
      .power  (pwr3)
   );

   assign acc = t3.first ? AW'(pwr3) : ram_q + AW'(pwr3);

   // Read one stage early; a bin recurs only every N samples.
   always_ff @(posedge i_clk) begin
      if (bus.i_ce) begin
         ram_q <= ram[t2.bin];
         if (t3.vld && !t3.fin) ram[t3.bin] <= acc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         bin_q  <= '0;
         pow_q  <= '0;
      end else if (bus.i_ce) begin
         vld_q <= t3.vld && t3.fin;
         if (t3.vld && t3.fin) begin
            bin_q  <= t3.bin;
            last_q <= (t3.bin == BLAST);
            pow_q  <= PWIDTH'(acc >> LGAVG);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) resync_q <= 1'b0;
      else         resync_q <= resync;
   end

   assign bus.o_valid  = vld_q && bus.i_ce;
   assign bus.o_last   = last_q && vld_q && bus.i_ce;
   assign bus.o_bin    = bin_q;
   assign bus.o_power  = pow_q;
   assign bus.o_resync = resync_q;

endmodule

// File: tb/tb_fftpower_avg.sv
// Directed bench for fftpower_avg: table of spectra plus corner sequences.
module tb_fftpower_avg;

   localparam int IW  = 20;
   localparam int LGW = 7;
   localparam int LGA = 4;
   localparam int PW  = 2 * IW;
   localparam int N   = 1 << LGW;
   localparam int LAT = 15 * N + 4;

   typedef struct {
      int            re;
      int            im;
      int            tone;
      bit            ramp;
      logic [PW-1:0] exp;
   } vec_t;

   typedef struct {
      int            bin;
      logic [PW-1:0] pwr;
      logic          last;
      int            cyc;
   } out_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   rs_cnt = 0;
   int   bad_v = 0;
   int   t0;
   out_t outq[$];
   vec_t vt[4];
   vec_t vg;

   fftpower_avg_if #(.IWIDTH(IW), .LGWIDTH(LGW), .PWIDTH(PW)) bus ();

   fftpower_avg #(
      .IWIDTH(IW), .LGWIDTH(LGW), .LGAVG(LGA), .PWIDTH(PW)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.o_valid === 1'b1) begin
         outq.push_back('{int'(bus.o_bin), bus.o_power,
                          bus.o_last, cyc});
         if (bus.i_ce !== 1'b1) bad_v++;
      end
      if (bus.o_resync === 1'b1) rs_cnt++;
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(bit ce, bit sync, int re, int im);
      @(posedge clk);
      #1;
      bus.i_ce     = ce;
      bus.i_sync   = sync;
      bus.i_sample = {IW'(re), IW'(im)};
   endtask

   function automatic void pat(vec_t v, int f, int b,
                               output int re, output int im);
      if (v.tone < 0 || v.tone == b) begin
         re = v.ramp ? v.re + f : v.re;
         im = v.im;
      end else begin
         re = 0;
         im = 0;
      end
   endfunction

   task automatic send(vec_t v, int ns, bit rnd, output int ts);
      int re, im, b, f;
      ts = -1;
      for (int s = 0; s < ns; s++) begin
         b = s % N;
         f = s / N;
         if (rnd && $urandom_range(0, 1) == 1)
            step(1'b0, 1'b1, 12345, -777);
         pat(v, f, b, re, im);
         step(1'b1, b == 0, re, im);
         if (ts < 0) ts = cyc;
      end
   endtask

   task automatic drain();
      repeat (8) step(1'b1, 1'b0, 0, 0);
      step(1'b0, 1'b0, 0, 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.i_ce = 1'b1;
      bus.i_sync = 1'b0;
      bus.i_sample = '1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      outq.delete();
      rs_cnt = 0;
      bad_v = 0;
   endtask

   task automatic check_spec(string tag, vec_t v, int ts, int rs_exp);
      logic [PW-1:0] ep;
      chk($sformatf("%s count", tag), outq.size(), N);
      chk($sformatf("%s resync", tag), rs_cnt, rs_exp);
      if (ts >= 0 && outq.size() > 0)
         chk($sformatf("%s latency", tag), outq[0].cyc - ts, LAT);
      foreach (outq[i]) begin
         ep = (v.tone < 0 || v.tone == i) ? v.exp : '0;
         chk($sformatf("%s bin[%0d]", tag, i), outq[i].bin, i);
         chk($sformatf("%s pwr[%0d]", tag, i), outq[i].pwr, ep);
         chk($sformatf("%s last[%0d]", tag, i),
             outq[i].last, i == N - 1);
      end
      outq.delete();
      rs_cnt = 0;
   endtask

   initial begin
      vt[0] = '{re: 1000, im: -500, tone: -1, ramp: 1'b0,
                exp: 40'd1250000};
      vt[1] = '{re: 524287, im: -524288, tone: 5, ramp: 1'b0,
                exp: 40'd549754765313};
      vt[2] = '{re: -524288, im: -524288, tone: 127, ramp: 1'b0,
                exp: 40'd549755813888};
      // re = frame 0..15, im = 3: (1240 + 16*9) / 16 = 86.5 -> 86
      vt[3] = '{re: 0, im: 3, tone: -1, ramp: 1'b1,
                exp: 40'd86};
      vg    = '{re: 7777, im: 3, tone: -1, ramp: 1'b0, exp: '0};

      rst = 1'b1;
      bus.i_ce = 1'b0;
      bus.i_sync = 1'b0;
      bus.i_sample = '0;

      for (int k = 0; k < 4; k++) begin
         do_reset();
         @(negedge clk);
         chk($sformatf("v%0d rst valid", k), bus.o_valid, 0);
         chk($sformatf("v%0d rst bin", k), bus.o_bin, 0);
         chk($sformatf("v%0d rst power", k), bus.o_power, 0);
         chk($sformatf("v%0d rst last", k), bus.o_last, 0);
         chk($sformatf("v%0d rst resync", k), bus.o_resync, 0);
         repeat (5) step(1'b1, 1'b0, 4321, -1234);
         send(vt[k], 16 * N, 1'b0, t0);
         drain();
         check_spec($sformatf("v%0d", k), vt[k], t0, 0);
      end

      do_reset();
      send(vt[3], 16 * N, 1'b1, t0);
      drain();
      check_spec("rndce", vt[3], -1, 0);
      chk("rndce valid_no_ce", bad_v, 0);

      do_reset();
      send(vg, 3 * N + 60, 1'b0, t0);
      send(vt[0], 16 * N, 1'b0, t0);
      drain();
      check_spec("resync", vt[0], t0, 1);

      do_reset();
      send(vg, 9 * N + 30, 1'b0, t0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst valid", bus.o_valid, 0);
      chk("midrst power", bus.o_power, 0);
      repeat (40) step(1'b1, 1'b0, 2222, 2222);
      send(vt[1], 16 * N, 1'b0, t0);
      drain();
      check_spec("midrst", vt[1], t0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
